// File: rtl/out_port_switch_arbiter_pkg.sv
// Shared router parameters: port count, buffer depth, clog2 helper and
// the switch-allocator state encoding.
package out_port_switch_arbiter_pkg;

  localparam int RTR_NUM_PORTS = 4;
  localparam int RTR_BUF_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/out_port_switch_arbiter_if.sv
// Request/grant/credit bundle between the input side of the router and one
// output-port allocator.
interface out_port_switch_arbiter_if #(
  parameter int P_NUM_IN     = 4,
  parameter int P_SEL_WIDTH  = 2,
  parameter int P_CRED_WIDTH = 3
);
  logic [P_NUM_IN-1:0]     REQ;
  logic [P_NUM_IN-1:0]     HEAD;
  logic [P_NUM_IN-1:0]     TAIL;
  logic                    CREDIT_IN;
  logic [P_NUM_IN-1:0]     GNT;
  logic                    FIRE;
  logic [P_SEL_WIDTH-1:0]  SEL;
  logic                    LOCKED;
  logic [P_SEL_WIDTH-1:0]  OWNER;
  logic [P_CRED_WIDTH-1:0] CREDIT_CNT;
  logic                    CREDIT_ERR;

  modport master (
    output REQ, HEAD, TAIL, CREDIT_IN,
    input  GNT, FIRE, SEL, LOCKED, OWNER, CREDIT_CNT, CREDIT_ERR
  );

  modport slave (
    input  REQ, HEAD, TAIL, CREDIT_IN,
    output GNT, FIRE, SEL, LOCKED, OWNER, CREDIT_CNT, CREDIT_ERR
  );
endinterface

// File: rtl/out_port_switch_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above the start
// pointer, wrapping around; shared with the VC allocator.
module rr_priority_pick #(
  parameter int P_N = 4,
  parameter int P_W = 2
) (
  input  logic [P_N-1:0] req_i,
  input  logic [P_W-1:0] ptr_i,
  output logic [P_N-1:0] gnt_o,
  output logic [P_W-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < P_N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= P_N) j = j - P_N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = P_W'(j);
      end
    end
  end

endmodule

// File: rtl/out_port_switch_arbiter.sv
// Output-port switch allocator: round-robin head arbitration, packet lock
// from head to tail, and credit-gated flit forwarding.
module out_port_switch_arbiter
  import out_port_switch_arbiter_pkg::*;
#(
  parameter int P_NUM_IN     = RTR_NUM_PORTS,
  parameter int P_BUF_DEPTH  = RTR_BUF_DEPTH,
  parameter int P_SEL_WIDTH  = clog2(P_NUM_IN),
  parameter int P_CRED_WIDTH = clog2(P_BUF_DEPTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  out_port_switch_arbiter_if.slave  bus
);

  localparam logic [P_CRED_WIDTH-1:0] DEPTH_C = P_CRED_WIDTH'(P_BUF_DEPTH);

  arb_state_e              state_q, state_d;
  logic [P_SEL_WIDTH-1:0]  owner_q, owner_d;
  logic [P_SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [P_CRED_WIDTH-1:0] cred_q, cred_d;
  logic                    err_q, err_d;

  logic [P_NUM_IN-1:0]     elig;
  logic [P_NUM_IN-1:0]     pick_gnt;
  logic [P_SEL_WIDTH-1:0]  pick_idx;
  logic                    pick_any;
  logic                    cred_ok;
  logic [P_NUM_IN-1:0]     gnt;
  logic [P_SEL_WIDTH-1:0]  sel;
  logic                    fire;

  function automatic logic [P_SEL_WIDTH-1:0] next_idx(input logic [P_SEL_WIDTH-1:0] x);
    return (int'(x) == P_NUM_IN - 1) ? '0 : x + 1'b1;
  endfunction

  assign cred_ok = (cred_q != '0);
  assign elig    = bus.REQ & bus.HEAD;

  rr_priority_pick #(
    .P_N (P_NUM_IN),
    .P_W (P_SEL_WIDTH)
  ) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grants are suppressed during reset even though the flops already hold
  // reset values, because a full credit count would otherwise let REQ through.
  always_comb begin
    gnt     = '0;
    sel     = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (!RST && cred_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt = pick_gnt;
            sel = pick_idx;
            if (bus.TAIL[pick_idx]) begin
              ptr_d = next_idx(pick_idx);
            end else begin
              state_d = ST_BUSY;
              owner_d = pick_idx;
            end
          end
        end
        ST_BUSY: begin
          if (bus.REQ[owner_q]) begin
            gnt[owner_q] = 1'b1;
            sel          = owner_q;
            if (bus.TAIL[owner_q]) begin
              state_d = ST_IDLE;
              ptr_d   = next_idx(owner_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fire = |gnt;

  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    case ({fire, bus.CREDIT_IN})
      2'b10:   cred_d = cred_q - 1'b1;
      2'b01: begin
        if (cred_q == DEPTH_C) err_d  = 1'b1;
        else                   cred_d = cred_q + 1'b1;
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cred_q  <= DEPTH_C;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  assign bus.GNT        = gnt;
  assign bus.FIRE       = fire;
  assign bus.SEL        = sel;
  assign bus.LOCKED     = (state_q == ST_BUSY);
  assign bus.OWNER      = owner_q;
  assign bus.CREDIT_CNT = cred_q;
  assign bus.CREDIT_ERR = err_q;

endmodule

// File: doc/out_port_switch_arbiter.md
Name: out_port_switch_arbiter

Overview:
- Per-output-port switch allocator for the wormhole NoC router.
- Shares one crossbar output among P_NUM_IN input ports using round-robin arbitration.
- Holds the grant from head flit to tail flit.
- Tracks the downstream input-buffer occupancy with credit-based flow control. A flit is forwarded only when at least one credit is available.

Parameters:
- P_NUM_IN, 4: number of requesting input ports (2..16).
- P_BUF_DEPTH, 4: downstream buffer depth in flits, which is also the initial credit count (1..255).
- P_SEL_WIDTH, clog2(P_NUM_IN): width of the owner/select index.
- P_CRED_WIDTH, clog2(P_BUF_DEPTH+1): width of the credit counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  P_NUM_IN  per-input flit-valid request for this output.
- HEAD  in  P_NUM_IN  per-input head-flit flag; qualified by REQ.
- TAIL  in  P_NUM_IN  per-input tail-flit flag; qualified by REQ. Single-flit packet = HEAD and TAIL both set.
- CREDIT_IN  in  1  one-cycle pulse: downstream freed one buffer slot.
- GNT  out  P_NUM_IN  one-hot flit transfer enable (combinational); the flit moves in this cycle.
- FIRE  out  1  OR of GNT.
- SEL  out  P_SEL_WIDTH  binary index of the granted input; crossbar mux select; valid when FIRE=1.
- LOCKED  out  1  registered; a packet currently owns the output.
- OWNER  out  P_SEL_WIDTH  registered; index of the locked input.
- CREDIT_CNT  out  P_CRED_WIDTH  registered available credits.
- CREDIT_ERR  out  1  registered, sticky credit-overflow flag.

Behaviour:
- Reset, asynchronous and immediate:
  - LOCKED=0, OWNER=0, round-robin pointer PTR=0.
  - CREDIT_CNT=P_BUF_DEPTH, CREDIT_ERR=0.
  - GNT, FIRE and SEL are forced to 0 while RST=1, regardless of REQ.
- State machine: IDLE (LOCKED=0) and BUSY (LOCKED=1).
- Credit gate: CRED_OK = (CREDIT_CNT != 0). No GNT bit may be set when CRED_OK=0.
- In IDLE:
  - Eligible set E = REQ & HEAD.
  - If E != 0 and CRED_OK: grant the first set bit of E found searching upward from PTR, wrapping modulo P_NUM_IN.
  - Winner w with TAIL[w]=1: stay in IDLE; PTR <= (w+1) mod P_NUM_IN.
  - Winner w with TAIL[w]=0: go to BUSY; OWNER <= w; PTR unchanged.
  - Requests without HEAD are ignored in IDLE; no grant, no error.
- In BUSY:
  - GNT[OWNER] = REQ[OWNER] & CRED_OK. All other inputs are blocked.
  - HEAD from the owner is treated as a body flit.
  - A granted flit with TAIL[OWNER]=1: go to IDLE and set PTR <= (OWNER+1) mod P_NUM_IN. The next packet can be granted in the following cycle.
  - An owner bubble (REQ low) keeps the lock.
- Credit counter, next value = CREDIT_CNT - FIRE + CREDIT_IN:
  - FIRE and CREDIT_IN in the same cycle: the count is unchanged.
  - CREDIT_IN while CREDIT_CNT=P_BUF_DEPTH and FIRE=0: the count saturates at P_BUF_DEPTH and CREDIT_ERR <= 1 until reset.
  - A returned credit at count 0 enables a grant one cycle after the CREDIT_IN pulse. There is no same-cycle bypass.
- Latency: request to grant is 0 cycles when a credit is available. Lock, pointer and credit updates take effect at the next rising edge.
- Reset mid-packet: lock and credits return to reset values. Upstream and downstream buffers are reset by the same RST.

Decomposition:
- Shared package (router parameters) holds:
  - the clog2 function;
  - state encoding constants for IDLE and BUSY;
  - the default buffer depth and port count shared with the router top and the input buffer.
- One combinational sub-module, rr_priority_pick:
  - inputs: request vector and start pointer;
  - outputs: one-hot winner, binary index and any-valid;
  - reused by the VC allocator.

Test Plan (P_NUM_IN=4, P_BUF_DEPTH=4):
1. RST=1 with REQ=HEAD=TAIL=4'hF -> GNT=0, FIRE=0, CREDIT_CNT=4, LOCKED=0. Release reset -> GNT=4'b0001 in the first cycle.
2. REQ=HEAD=TAIL=4'hF held, with CREDIT_IN pulsed each cycle one cycle after FIRE -> GNT sequence 0001,0010,0100,1000,0001.
3. Input 2 sends head/body/body/tail over cycles 0-3 while input 0 holds a head request -> GNT=4'b0100 for cycles 0-3, LOCKED=1 for cycles 1-3, GNT=4'b0001 in cycle 4.
4. Input 1 sends a 6-flit packet with no CREDIT_IN -> four grants, then GNT=0 with REQ held and CREDIT_CNT=0. CREDIT_IN pulse at cycle t -> GNT=4'b0010 at t+1.
5. CREDIT_CNT=1 with FIRE and CREDIT_IN in the same cycle -> CREDIT_CNT stays 1. CREDIT_IN at CREDIT_CNT=4 with no FIRE -> CREDIT_CNT=4, CREDIT_ERR=1 and still 1 after 10 idle cycles.
6. RST asserted mid-packet while LOCKED=1 and OWNER=3 -> LOCKED=0, OWNER=0, CREDIT_CNT=4 without waiting for a clock edge. After release, a head from input 0 is granted.
